// File: rtl/instr_mem_writer_pkg.sv
// Shared constants and types for the instruction-memory writer: format codes,
// opcode values, MIPS field bit positions and the writer FSM state type.
package instr_mem_writer_pkg;

    localparam logic [1:0] FMT_R = 2'd0;
    localparam logic [1:0] FMT_I = 2'd1;
    localparam logic [1:0] FMT_J = 2'd2;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int JADDR_MSB  = 25;
    localparam int JADDR_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        ADVANCE = 2'd2,
        VERIFY  = 2'd3
    } state_t;

    // I-type may not reuse the R-type or J opcode; J-type must be J or JAL.
    function automatic logic is_legal(input logic [1:0] fmt, input logic [5:0] opcode);
        logic ok;
        ok = 1'b0;
        case (fmt)
            FMT_R:   ok = 1'b1;
            FMT_I:   ok = (opcode != OP_RTYPE) && (opcode != OP_J);
            FMT_J:   ok = (opcode == OP_J) || (opcode == OP_JAL);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/instr_mem_writer_packer.sv
// Combinational packer: decoded MIPS fields -> 32-bit R/I/J word, plus a flag
// marking bundles that must be rejected.
module instr_mem_writer_packer
    import instr_mem_writer_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [5:0]  opcode,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] jaddr,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word = '0;
        case (fmt)
            FMT_R: begin
                word[OPCODE_MSB:OPCODE_LSB] = OP_RTYPE;
                word[RS_MSB:RS_LSB]         = rs;
                word[RT_MSB:RT_LSB]         = rt;
                word[RD_MSB:RD_LSB]         = rd;
                word[SHAMT_MSB:SHAMT_LSB]   = shamt;
                word[FUNCT_MSB:FUNCT_LSB]   = funct;
            end
            FMT_I: begin
                word[OPCODE_MSB:OPCODE_LSB] = opcode;
                word[RS_MSB:RS_LSB]         = rs;
                word[RT_MSB:RT_LSB]         = rt;
                word[IMM_MSB:IMM_LSB]       = imm;
            end
            FMT_J: begin
                word[OPCODE_MSB:OPCODE_LSB] = opcode;
                word[JADDR_MSB:JADDR_LSB]   = jaddr;
            end
            default: word = '0;
        endcase
    end

    assign illegal = !is_legal(fmt, opcode);

endmodule

// File: rtl/instr_mem_writer.sv
// Writes packed instructions to consecutive words of the shared mem block.
// Define INSTR_WRITER_VERIFY_EN to add a read-back VERIFY cycle after each write.
module instr_mem_writer
    import instr_mem_writer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h28,
    parameter int          MAX_WORDS = 11,
    parameter int          ADDR_STEP = 4,
    localparam int         CW        = $clog2(MAX_WORDS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    fmt,
    input  logic [5:0]    opcode,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    input  logic [4:0]    rd,
    input  logic [4:0]    shamt,
    input  logic [5:0]    funct,
    input  logic [15:0]   imm,
    input  logic [25:0]   jaddr,
    output logic [31:0]   address,
    output logic [31:0]   memIn,
    output logic          write,
    output logic          read,
    input  logic [31:0]   memOut,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          err,
    output state_t        state_dbg
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);
    localparam logic [31:0]   STEP    = 32'(ADDR_STEP);

    // Handshake: a bundle transfers on a rising edge where in_valid and
    // in_ready are both high; fields are sampled only on that edge.
    state_t        state;
    logic [31:0]   packed_word;
    logic          illegal;
    logic          accept;
    logic [CW-1:0] count_inc;

    instr_mem_writer_packer u_packer (
        .fmt     (fmt),
        .opcode  (opcode),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .shamt   (shamt),
        .funct   (funct),
        .imm     (imm),
        .jaddr   (jaddr),
        .word    (packed_word),
        .illegal (illegal)
    );

    assign in_ready  = (state == IDLE) && !full && !start;
    assign accept    = in_valid && in_ready;
    assign count_inc = count + CW'(1);
    assign state_dbg = state;

`ifndef INSTR_WRITER_VERIFY_EN
    logic unused_memout;
    assign unused_memout = ^memOut;
    assign read          = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            address <= BASE_ADDR;
            memIn   <= '0;
            write   <= 1'b0;
`ifdef INSTR_WRITER_VERIFY_EN
            read    <= 1'b0;
`endif
            count   <= '0;
            full    <= 1'b0;
            err     <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        address <= BASE_ADDR;
                        count   <= '0;
                        full    <= 1'b0;
                    end else if (accept) begin
                        // Rejected bundles still complete the handshake.
                        if (illegal) begin
                            err <= 1'b1;
                        end else begin
                            memIn <= packed_word;
                            write <= 1'b1;
                            state <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    write <= 1'b0;
`ifdef INSTR_WRITER_VERIFY_EN
                    read  <= 1'b1;
                    state <= VERIFY;
`else
                    address <= address + STEP;
                    count   <= count_inc;
                    full    <= (count_inc == MAX_CNT);
                    state   <= ADVANCE;
`endif
                end
`ifdef INSTR_WRITER_VERIFY_EN
                VERIFY: begin
                    // A mismatch is flagged but the word still counts.
                    read    <= 1'b0;
                    err     <= (memOut != memIn);
                    address <= address + STEP;
                    count   <= count_inc;
                    full    <= (count_inc == MAX_CNT);
                    state   <= ADVANCE;
                end
`endif
                ADVANCE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_writer.sv
// Randomized self-checking bench for instr_mem_writer against a transaction-level model.
module tb_instr_mem_writer;
  import instr_mem_writer_pkg::*;

  localparam logic [31:0] BASE = 32'h28;
  localparam int MAXW = 11;
  localparam logic [31:0] STEP = 32'd4;
`ifdef INSTR_WRITER_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic start = 1'b0, in_valid = 1'b0, in_ready;
  logic [1:0] fmt = '0;
  logic [5:0] opcode = '0, funct = '0;
  logic [4:0] rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [15:0] imm = '0;
  logic [25:0] jaddr = '0;
  logic [31:0] address, memIn, memOut;
  logic write, read, full, err;
  logic [3:0] count;
  state_t state_dbg;

  instr_mem_writer #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .ADDR_STEP(4)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm(imm), .jaddr(jaddr), .address(address), .memIn(memIn), .write(write), .read(read),
    .memOut(memOut), .count(count), .full(full), .err(err), .state_dbg(state_dbg)
  );

  // memory stand-in: returns the last written word, optionally corrupted
  logic [31:0] last_wr = '0;
  bit corrupt = 1'b0;
  always @(posedge clk) if (write) last_wr <= memIn;
  assign memOut = last_wr ^ (corrupt ? 32'h0000_0100 : 32'h0);

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: word encoding from field weights, legality from the rules
  function automatic logic [31:0] enc(input logic [1:0] f, input logic [5:0] op,
      input logic [4:0] s, input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
      input logic [5:0] fn, input logic [15:0] im, input logic [25:0] ja);
    logic [31:0] w;
    case (f)
      2'd0: w = 32'(s) * 32'h20_0000 + 32'(t) * 32'h1_0000 + 32'(d) * 32'h800 + 32'(sh) * 32'd64 + 32'(fn);
      2'd1: w = 32'(op) * 32'h400_0000 + 32'(s) * 32'h20_0000 + 32'(t) * 32'h1_0000 + 32'(im);
      2'd2: w = 32'(op) * 32'h400_0000 + 32'(ja);
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  function automatic bit legal(input logic [1:0] f, input logic [5:0] op);
    if (f == 2'd0) return 1'b1;
    if (f == 2'd1) return (op != 6'd0) && (op != 6'd2);
    if (f == 2'd2) return (op == 6'd2) || (op == 6'd3);
    return 1'b0;
  endfunction

  // model state: since = edges elapsed since the last legal accept, -1 when idle
  logic [31:0] m_addr, m_data;
  logic [3:0] m_count;
  bit m_write, m_read, m_err;
  int since;
  logic [31:0] exp_q[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_addr <= BASE; m_data <= '0; m_count <= '0;
      m_write <= 1'b0; m_read <= 1'b0; m_err <= 1'b0; since <= -1;
    end else begin
      m_err <= 1'b0;
      if (since == 0) begin
        m_write <= 1'b0;
        since <= 1;
        if (VER) m_read <= 1'b1;
        else begin m_addr <= m_addr + STEP; m_count <= m_count + 4'd1; end
      end else if (since == 1) begin
        if (VER) begin
          m_read <= 1'b0; m_err <= corrupt;
          m_addr <= m_addr + STEP; m_count <= m_count + 4'd1;
          since <= 2;
        end else since <= -1;
      end else if (since == 2) begin
        since <= -1;
      end else if (start) begin
        m_addr <= BASE; m_count <= '0;
      end else if (in_valid && m_count != 4'(MAXW)) begin
        if (legal(fmt, opcode)) begin
          m_data <= enc(fmt, opcode, rs, rt, rd, shamt, funct, imm, jaddr);
          m_write <= 1'b1;
          since <= 0;
          exp_q.push_back(enc(fmt, opcode, rs, rt, rd, shamt, funct, imm, jaddr));
        end else m_err <= 1'b1;
      end
    end
  end

  // scoreboard: every write strobe must carry the next expected word
  always @(negedge clk) begin
    if (chk_on && !reset && write) begin
      if (exp_q.size() == 0) check("unexpected_write", memIn, 32'hxxxx_xxxx);
      else check("sb_word", memIn, exp_q.pop_front());
    end
  end

  // cycle compare of all outputs against the model
  always @(negedge clk) begin
    if (chk_on && !reset) begin
      check("in_ready", 32'(in_ready), 32'((since < 0) && (m_count != 4'(MAXW)) && !start));
      check("address", address, m_addr);
      check("memIn", memIn, m_data);
      check("write", 32'(write), 32'(m_write));
      check("read", 32'(read), 32'(m_read));
      check("count", 32'(count), 32'(m_count));
      check("full", 32'(full), 32'(m_count == 4'(MAXW)));
      check("err", 32'(err), 32'(m_err));
    end
  end

  // driver tasks
  task automatic set_fields(input logic [1:0] f, input logic [5:0] op, input logic [4:0] s,
      input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh, input logic [5:0] fn,
      input logic [15:0] im, input logic [25:0] ja);
    fmt = f; opcode = op; rs = s; rt = t; rd = d; shamt = sh; funct = fn; imm = im; jaddr = ja;
  endtask

  task automatic set_rand(input bit only_legal);
    logic [1:0] f;
    logic [5:0] op;
    f = only_legal ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 3));
    if (f == 2'd2) op = only_legal ? 6'(2 + $urandom_range(0, 1)) : 6'($urandom_range(0, 4));
    else if (only_legal && f == 2'd1) op = 6'($urandom_range(4, 63));
    else op = 6'($urandom_range(0, 63));
    set_fields(f, op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
               6'($urandom), 16'($urandom), 26'($urandom));
  endtask

  task automatic handshake(input int budget, output bit acc);
    bit r;
    acc = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < budget && !acc; i++) begin
      @(negedge clk); r = in_ready;
      @(posedge clk); #1;
      if (r) acc = 1'b1;
    end
    in_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 10 && since >= 0; i++) step(1);
    if (since >= 0) check("idle_timeout", 32'(since), 32'hFFFF_FFFF);
  endtask

  task automatic do_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    step(2);
    reset = 1'b0;
    chk_on = 1'b1;

    // reset values
    check("rst_address", address, 32'h28);
    check("rst_count", 32'(count), 32'd0);
    check("rst_memIn", memIn, 32'd0);
    check("rst_flags", {28'd0, write, read, full, err}, 32'd0);

    // model pins
    check("enc_r", enc(2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'd32, 16'd0, 26'd0), 32'h0022_1820);
    check("enc_i", enc(2'd1, 6'd8, 5'd0, 5'd5, 5'd0, 5'd0, 6'd0, 16'd7, 26'd0), 32'h2005_0007);
    check("enc_j", enc(2'd2, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10), 32'h0800_0010);
    check("legal_pin", {29'd0, legal(2'd1, 6'd0), legal(2'd2, 6'd3), legal(2'd3, 6'd9)}, 32'd2);

    // R bundle; non-zero opcode input must be forced to 0
    set_fields(2'd0, 6'h3F, 5'd1, 5'd2, 5'd3, 5'd0, 6'd32, 16'hFFFF, 26'h3FF_FFFF);
    handshake(10, acc);
    check("acc_r", 32'(acc), 32'd1);
    check("r_write", 32'(write), 32'd1);
    check("r_addr", address, 32'h28);
    check("r_data", memIn, 32'h0022_1820);
    wait_idle();
    check("r_count", 32'(count), 32'd1);
    check("r_next_addr", address, 32'h2C);

    // I then J
    set_fields(2'd1, 6'd8, 5'd0, 5'd5, 5'd0, 5'd0, 6'd0, 16'd7, 26'd0);
    handshake(10, acc);
    check("i_addr", address, 32'h2C);
    check("i_data", memIn, 32'h2005_0007);
    wait_idle();
    set_fields(2'd2, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10);
    handshake(10, acc);
    check("j_addr", address, 32'h30);
    check("j_data", memIn, 32'h0800_0010);
    wait_idle();

    // illegal bundles: err pulse, no write, state kept
    set_fields(2'd1, 6'd0, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'd1, 26'd0);
    handshake(10, acc);
    check("ill_i_err", 32'(err), 32'd1);
    check("ill_i_write", 32'(write), 32'd0);
    set_fields(2'd3, 6'd4, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'd1, 26'd0);
    handshake(10, acc);
    check("ill_f3_acc", 32'(acc), 32'd1);
    check("ill_f3_err", 32'(err), 32'd1);
    step(1);
    check("ill_err_clear", 32'(err), 32'd0);
    check("ill_addr", address, 32'h34);
    check("ill_count", 32'(count), 32'd3);

    // randomized traffic
    repeat (150) begin
      step($urandom_range(0, 2));
      wait_idle();
      if (count == 4'(MAXW) || $urandom_range(0, 14) == 0) do_start();
      if (VER) corrupt = ($urandom_range(0, 3) == 0);
      set_rand(1'b0);
      handshake(12, acc);
      check("rand_acc", 32'(acc), 32'd1);
      if ($urandom_range(0, 9) == 0) do_start();
    end
    corrupt = 1'b0;
    wait_idle();

    // fill to MAX_WORDS with in_valid held, then a 12th bundle is refused
    do_start();
    for (int n = 0; n < MAXW; n++) begin
      set_rand(1'b1);
      handshake(12, acc);
      check("fill_acc", 32'(acc), 32'd1);
    end
    wait_idle();
    check("fill_full", 32'(full), 32'd1);
    check("fill_addr", address, 32'h54);
    check("fill_count", 32'(count), 32'd11);
    check("fill_ready", 32'(in_ready), 32'd0);
    set_rand(1'b1);
    handshake(8, acc);
    check("acc_12th", 32'(acc), 32'd0);
    check("no_write_12th", 32'(write), 32'd0);

    // reset during a WRITE cycle
    do_start();
    set_rand(1'b1);
    handshake(10, acc);
    check("pre_rst_write", 32'(write), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_write", 32'(write), 32'd0);
    check("rst_mid_addr", address, 32'h28);
    check("rst_mid_count", 32'(count), 32'd0);
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;

    // start wins over a same-cycle valid bundle
    set_rand(1'b1);
    in_valid = 1'b1; start = 1'b1;
    @(negedge clk);
    check("start_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    check("start_no_write", 32'(write), 32'd0);
    check("start_count", 32'(count), 32'd0);

`ifdef INSTR_WRITER_VERIFY_EN
    // corrupted read-back
    corrupt = 1'b1;
    set_rand(1'b1);
    handshake(10, acc);
    step(1);
    check("ver_read", 32'(read), 32'd1);
    check("ver_no_write", 32'(write), 32'd0);
    step(1);
    check("ver_err", 32'(err), 32'd1);
    check("ver_addr", address, 32'h2C);
    corrupt = 1'b0;
`endif

    step(4);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
